envelope_follower: RTL and testbench
====================================

# envelope_follower

Audio envelope detector and gate extractor: rectifies a signed sample stream, smooths it with independent attack/release slew rates, and derives a hysteretic gate with optional hold time. It sits after an audio source (ADC, mixer bus, oscillator) and drives the `gate` input of the ADSR envelope generator or any other gate-consuming core. Everything runs at system clock and is qualified by a per-sample strobe.

## Interface
- `BITSIZE`, 16: audio sample width, signed.
- `ACCUMULATOR_BITS`, 20: envelope accumulator width; must be greater than `BITSIZE`.
- `PARAMETERS_BITS`, 16: width of `att`, `rel`, `thr_on`, `thr_off`, `hold`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  one-cycle strobe marking a new `in` sample.
- `in`  in  BITSIZE signed  audio sample.
- `att`  in  PARAMETERS_BITS  accumulator increment per sample while rising.
- `rel`  in  PARAMETERS_BITS  accumulator decrement per sample while falling.
- `thr_on`  in  PARAMETERS_BITS  envelope level that opens the gate.
- `thr_off`  in  PARAMETERS_BITS  envelope level below which the gate closes.
- `hold`  in  PARAMETERS_BITS  samples to keep the gate open after falling below `thr_off`.
- `env`  out  BITSIZE unsigned  smoothed envelope, 0..2^(BITSIZE-1)-1.
- `env_valid`  out  1  one-cycle pulse when `env`/`gate` reflect a new sample.
- `gate`  out  1  gate level.
- `gate_rise`  out  1  one-cycle pulse on gate opening.

## Operation
- Stage 1, rectify: `rect = |in|`; the most negative input saturates to 2^(BITSIZE-1)-1.
- Stage 2, slew: `target = rect << (ACCUMULATOR_BITS-BITSIZE)`, unsigned, ACCUMULATOR_BITS wide.
  - `acc < target`: `acc <= min(acc + att, target)`.
  - `acc > target`: `acc <= max(acc - rel, target)`, computed without underflow.
  - Equal: hold the value. `att = 0` or `rel = 0` freezes that direction.
  - `env = acc[ACCUMULATOR_BITS-1 -: BITSIZE]`.
- Stage 3, gate FSM with states IDLE, OPEN, HOLD. It evaluates once per processed sample.
  - IDLE -> OPEN when `env >= thr_on`; pulse `gate_rise`.
  - OPEN -> HOLD when `env < thr_off`; clear the hold counter. If `hold == 0`, go straight to IDLE.
  - HOLD -> OPEN when `env >= thr_on`, with no `gate_rise`.
  - HOLD: increment the counter each sample; when it reaches `hold`, go to IDLE.
  - `gate = 1` in OPEN and HOLD.
  - Open is tested only in IDLE/HOLD and close only in OPEN, so `thr_off > thr_on` cannot cause a same-sample conflict.
- Parameters are sampled at the cycle they are used. Changing them mid-stream takes effect on the next sample.
- Reset values: `acc`, `env`, `env_valid`, `gate`, `gate_rise`, hold counter = 0; FSM = IDLE; pipeline valid flags cleared.

## Timing
- `sample_valid` at cycle t:
  - `rect` registered at t+1.
  - `acc`/`env` updated at t+2.
  - FSM, `gate`, `gate_rise` and `env_valid` updated at t+3.
- Fully pipelined: `sample_valid` may assert every cycle, and each sample is processed independently in order.
- Without `sample_valid`, no state changes. `env` and `gate` hold their values; `env_valid` and `gate_rise` are 0.
- `reset` asserted mid-pipeline discards in-flight samples. No `env_valid` pulse is produced for them. Outputs read reset values at the cycle after reset.
- `reset` and `sample_valid` in the same cycle: reset wins and the sample is dropped.

## Configuration
- `ENV_FOLLOWER_HOLD_EN` defined: the HOLD state and hold counter are implemented as above.
- Undefined: no HOLD state or counter. OPEN -> IDLE directly when `env < thr_off`. The `hold` port remains present and is ignored.

## Test plan
- Reset: drive `reset` for 2 cycles with random inputs -> `env = 0`, `gate = 0`, `env_valid = 0`, `gate_rise = 0`.
- Attack clamp: `att = 0x1000`, `in = 16000` every sample -> `env` rises 256 per sample (15872 after 62 samples) and is exactly 16000 at sample 63, with no overshoot afterwards.
- Release and rectify: settle at `in = -16000` (so `env = 16000`), then `in = 0` with `rel = 0x0800` -> `env` falls 128 per sample and reaches 0 after 125 samples. Also drive `in = -32768` and confirm `rect = 32767`.
- Hysteresis: `thr_on = 8000`, `thr_off = 4000`, `att = rel = 0x1000`, hold = 0 -> `gate_rise` pulses once at the sample where `env` first crosses 8000. The gate stays high while `env` sits between 4000 and 8000 and drops at the first sample below 4000.
- Hold (macro on): `hold = 10` -> `gate` stays high exactly 10 samples after `env < thr_off`. Re-crossing `thr_on` at sample 5 returns to OPEN with no `gate_rise`. With the macro off, the gate drops immediately.
- Back-to-back and latency: `sample_valid` held high every cycle -> one `env_valid` per sample, each 3 cycles after its `sample_valid`. Reset asserted mid-burst -> no stale `env_valid`.

Source files
------------

// File: rtl/envelope_follower.sv
// Envelope follower: rectify -> attack/release slew -> hysteretic gate FSM, 3-stage pipeline.
// Optional hold state and counter enabled by defining ENV_FOLLOWER_HOLD_EN.
module envelope_follower #(
    parameter int BITSIZE          = 16,
    parameter int ACCUMULATOR_BITS = 20,
    parameter int PARAMETERS_BITS  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic signed [BITSIZE-1:0]  in,
    input  logic [PARAMETERS_BITS-1:0] att,
    input  logic [PARAMETERS_BITS-1:0] rel,
    input  logic [PARAMETERS_BITS-1:0] thr_on,
    input  logic [PARAMETERS_BITS-1:0] thr_off,
    input  logic [PARAMETERS_BITS-1:0] hold,
    output logic [BITSIZE-1:0]         env,
    output logic                       env_valid,
    output logic                       gate,
    output logic                       gate_rise,
    output logic [1:0]                 dbg_state
);
    localparam int SHIFT = ACCUMULATOR_BITS - BITSIZE;
    localparam logic [BITSIZE-1:0] MOST_NEG = {1'b1, {(BITSIZE-1){1'b0}}};
    localparam logic [BITSIZE-1:0] MAX_POS  = {1'b0, {(BITSIZE-1){1'b1}}};

`ifdef ENV_FOLLOWER_HOLD_EN
    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_HOLD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_OPEN} state_t;
`endif

    // Stage 1: rectify
    logic [BITSIZE-1:0] w_in_u;
    logic [BITSIZE-1:0] w_rect;
    logic [BITSIZE-1:0] r_rect;
    logic               r_v1;

    assign w_in_u = in;

    always_comb begin
        w_rect = w_in_u;
        if (w_in_u == MOST_NEG)
            w_rect = MAX_POS;
        else if (w_in_u[BITSIZE-1])
            w_rect = ~w_in_u + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_rect <= '0;
        end else begin
            r_v1 <= sample_valid;
            if (sample_valid)
                r_rect <= w_rect;
        end
    end

    // Stage 2: slew toward target; all arithmetic kept non-negative by comparing first
    logic [ACCUMULATOR_BITS-1:0] r_acc;
    logic                        r_v2;
    logic [ACCUMULATOR_BITS-1:0] w_target;
    logic [ACCUMULATOR_BITS:0]   w_up;
    logic [ACCUMULATOR_BITS-1:0] w_gap;
    logic [ACCUMULATOR_BITS-1:0] w_rel_ext;
    logic [ACCUMULATOR_BITS-1:0] w_acc_nx;
    logic [BITSIZE-1:0]          w_env;

    assign w_target  = {r_rect, {SHIFT{1'b0}}};
    assign w_up      = {1'b0, r_acc} + {{(ACCUMULATOR_BITS+1-PARAMETERS_BITS){1'b0}}, att};
    assign w_rel_ext = {{(ACCUMULATOR_BITS-PARAMETERS_BITS){1'b0}}, rel};
    assign w_gap     = r_acc - w_target;
    assign w_env     = r_acc[ACCUMULATOR_BITS-1 -: BITSIZE];

    always_comb begin
        w_acc_nx = r_acc;
        if (r_acc < w_target) begin
            if (w_up >= {1'b0, w_target})
                w_acc_nx = w_target;
            else
                w_acc_nx = w_up[ACCUMULATOR_BITS-1:0];
        end else if (r_acc > w_target) begin
            if (w_gap <= w_rel_ext)
                w_acc_nx = w_target;
            else
                w_acc_nx = r_acc - w_rel_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v2  <= 1'b0;
            r_acc <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1)
                r_acc <= w_acc_nx;
        end
    end

    // Stage 3: gate FSM, evaluated only for samples leaving stage 2
    state_t r_state;
    state_t w_state_nx;
    logic   w_rise_nx;
    logic   r_gate;
    logic   r_gate_rise;
    logic   r_env_valid;
`ifdef ENV_FOLLOWER_HOLD_EN
    logic [PARAMETERS_BITS-1:0] r_hold_cnt;
    logic [PARAMETERS_BITS-1:0] w_cnt_nx;
`else
    logic w_unused_hold;
    assign w_unused_hold = ^hold;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_rise_nx  = 1'b0;
`ifdef ENV_FOLLOWER_HOLD_EN
        w_cnt_nx   = r_hold_cnt;
`endif
        if (r_v2) begin
            case (r_state)
                S_IDLE: begin
                    if (w_env >= thr_on) begin
                        w_state_nx = S_OPEN;
                        w_rise_nx  = 1'b1;
                    end
                end
                S_OPEN: begin
                    if (w_env < thr_off) begin
`ifdef ENV_FOLLOWER_HOLD_EN
                        if (hold == '0) begin
                            w_state_nx = S_IDLE;
                        end else begin
                            w_state_nx = S_HOLD;
                            w_cnt_nx   = '0;
                        end
`else
                        w_state_nx = S_IDLE;
`endif
                    end
                end
`ifdef ENV_FOLLOWER_HOLD_EN
                S_HOLD: begin
                    // >= keeps the count bounded if hold is lowered while counting
                    if (w_env >= thr_on)
                        w_state_nx = S_OPEN;
                    else if (r_hold_cnt >= hold)
                        w_state_nx = S_IDLE;
                    else
                        w_cnt_nx = r_hold_cnt + 1'b1;
                end
`endif
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gate      <= 1'b0;
            r_gate_rise <= 1'b0;
            r_env_valid <= 1'b0;
`ifdef ENV_FOLLOWER_HOLD_EN
            r_hold_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_gate      <= (w_state_nx != S_IDLE);
            r_gate_rise <= w_rise_nx;
            r_env_valid <= r_v2;
`ifdef ENV_FOLLOWER_HOLD_EN
            r_hold_cnt  <= w_cnt_nx;
`endif
        end
    end

    assign env       = w_env;
    assign env_valid = r_env_valid;
    assign gate      = r_gate;
    assign gate_rise = r_gate_rise;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower: reset, attack/release slew, rectify, hysteresis,
// hold behaviour (depends on ENV_FOLLOWER_HOLD_EN) and pipeline latency.
module tb_envelope_follower;
`ifdef ENV_FOLLOWER_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic signed [15:0] in_s;
    logic [15:0]        att, rel, thr_on, thr_off, hold;
    logic [15:0]        env;
    logic               env_valid, gate, gate_rise;
    logic [1:0]         dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    envelope_follower dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .in(in_s),
        .att(att), .rel(rel), .thr_on(thr_on), .thr_off(thr_off), .hold(hold),
        .env(env), .env_valid(env_valid), .gate(gate), .gate_rise(gate_rise),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Two reset cycles with random inputs; returns #1 after an edge with reset released
    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'($urandom_range(0, 1));
        in_s         = 16'($urandom);
        att          = 16'($urandom);
        rel          = 16'($urandom);
        thr_on       = 16'($urandom);
        thr_off      = 16'($urandom);
        hold         = 16'($urandom);
        repeat (2) begin
            @(posedge clk); #1;
            sample_valid = 1'($urandom_range(0, 1));
            in_s         = 16'($urandom);
        end
        reset        = 1'b0;
        sample_valid = 1'b0;
    endtask

    // One sample in, wait until its env_valid is visible
    task automatic send(input logic signed [15:0] x);
        in_s         = x;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_env;
        // Reset values
        do_reset();
        check("rst_env", env, 0);
        check("rst_gate", gate, 0);
        check("rst_env_valid", env_valid, 0);
        check("rst_gate_rise", gate_rise, 0);

        // Attack with clamp at target
        do_reset();
        att = 16'h1000; rel = 16'h0000; thr_on = 16'hFFFF; thr_off = 16'h0000; hold = 0;
        for (int n = 1; n <= 66; n++) begin
            send(16'sd16000);
            exp_env = (n <= 62) ? 256 * n : 16000;
            check("atk_env", env, exp_env);
            check("atk_valid", env_valid, 1);
        end
        check("atk_gate", gate, 0);

        // Release: equal target holds, then 128 per sample down to 0 without underflow
        rel = 16'h0800;
        send(-16'sd16000);
        check("rel_hold_eq", env, 16000);
        for (int n = 1; n <= 127; n++) begin
            send(16'sd0);
            exp_env = (n <= 125) ? 16000 - 128 * n : 0;
            check("rel_env", env, exp_env);
        end
        att = 16'h0000;
        repeat (3) send(16'sd100);
        check("att_freeze", env, 0);

        // Most negative input saturates
        att = 16'hFFFF; rel = 16'h0000;
        repeat (7) send(-16'sd32768);
        check("sat_mid", env, 28671);
        repeat (3) send(-16'sd32768);
        check("sat_env", env, 32767);
        rel = 16'hFFFF;
        repeat (7) send(16'sd0);
        check("fast_rel_mid", env, 4095);
        repeat (2) send(16'sd0);
        check("fast_rel_zero", env, 0);

        // Hysteresis with hold = 0
        do_reset();
        att = 16'h1000; rel = 16'h1000; thr_on = 16'd8000; thr_off = 16'd4000; hold = 0;
        for (int n = 1; n <= 40; n++) begin
            send(16'sd16000);
            check("hys_up_env", env, 256 * n);
            check("hys_up_rise", gate_rise, (n == 32) ? 1 : 0);
            check("hys_up_gate", gate, (n >= 32) ? 1 : 0);
        end
        for (int k = 1; k <= 20; k++) begin
            send(16'sd6000);
            exp_env = (k <= 16) ? 10240 - 256 * k : 6000;
            check("hys_mid_env", env, exp_env);
            check("hys_mid_gate", gate, 1);
            check("hys_mid_rise", gate_rise, 0);
        end
        for (int j = 1; j <= 10; j++) begin
            send(16'sd0);
            check("hys_dn_env", env, 6000 - 256 * j);
            check("hys_dn_gate", gate, (j <= 7) ? 1 : 0);
        end

        // Hold time after falling below thr_off
        do_reset();
        att = 16'h1000; rel = 16'h1000; thr_on = 16'd8000; thr_off = 16'd4000; hold = 16'd10;
        repeat (40) send(16'sd16000);
        check("hold_pre_gate", gate, 1);
        for (int k = 1; k <= 40; k++) begin
            send(16'sd0);
            check("hold_env", env, 10240 - 256 * k);
            check("hold_gate", gate, (k <= (HOLD_EN ? 35 : 24)) ? 1 : 0);
            check("hold_rise", gate_rise, 0);
        end

        // Re-cross thr_on during hold: back to OPEN without gate_rise
        do_reset();
        att = 16'h1000; rel = 16'h1000; thr_on = 16'd8000; thr_off = 16'd4000; hold = 16'd10;
        repeat (40) send(16'sd16000);
        repeat (28) send(16'sd0);
        check("rx_env28", env, 3072);
        check("rx_gate28", gate, HOLD_EN ? 1 : 0);
        att = 16'hFFFF;
        send(16'sd16000);
        check("rx_env29", env, 7167);
        check("rx_gate29", gate, HOLD_EN ? 1 : 0);
        send(16'sd16000);
        check("rx_env30", env, 11263);
        check("rx_gate30", gate, 1);
        check("rx_rise30", gate_rise, HOLD_EN ? 0 : 1);

        // Back-to-back samples: env at +2 cycles, env_valid at +3 cycles
        do_reset();
        att = 16'h1000; rel = 16'h0000; thr_on = 16'hFFFF; thr_off = 16'h0000; hold = 0;
        in_s = 16'sd16000;
        for (int c = 0; c < 14; c++) begin
            sample_valid = (c < 8);
            check("b2b_valid", env_valid, (c >= 3 && c <= 10) ? 1 : 0);
            exp_env = (c < 2) ? 0 : (c >= 9) ? 2048 : 256 * (c - 1);
            check("b2b_env", env, exp_env);
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;

        // Reset mid-burst discards in-flight samples; reset beats sample_valid
        do_reset();
        att = 16'h1000; rel = 16'h0000; thr_on = 16'hFFFF; thr_off = 16'h0000; hold = 0;
        in_s = 16'sd16000;
        for (int c = 0; c < 12; c++) begin
            sample_valid = (c <= 5);
            reset        = (c == 4);
            check("mid_rst_valid", env_valid, (c == 3 || c == 4 || c == 8) ? 1 : 0);
            if (c == 5) check("mid_rst_env", env, 0);
            if (c == 7) check("post_rst_env", env, 256);
            @(posedge clk); #1;
        end
        reset        = 1'b0;
        sample_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
